marmot_wb_sram_bridge: RTL and testbench

Wishbone classic slave that gives the Caravel management core direct read/write access to the Marmot D-cache data SRAM macros (four banks of 512 x 64-bit). It sits between the user-project Wishbone port and the `data_arrays_0_0_ext_ram_*` macro pins, and is used for SRAM bring-up, BIST-free test and cache preload. Byte-granular Wishbone writes are mapped onto the macros' 32-bit write-mask granularity, using read-modify-write when it is compiled in.

---
 rtl/marmot_wb_sram_pkg.sv | 29 ++
 rtl/marmot_sram_lane_mux.sv | 28 ++
 rtl/marmot_wb_sram_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_marmot_wb_sram_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/marmot_wb_sram_pkg.sv
// Shared types and helpers for the Wishbone-to-D-cache-SRAM bridge.
// Partial-write read-modify-write is enabled by defining MARMOT_WB_SRAM_RMW_EN.
package marmot_wb_sram_pkg;

  localparam int BANKS  = 4;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 9;
  localparam int RAM_DW = 64;
  localparam int LANE_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WBACK,
    ACK
  } state_t;

  // Byte-wise merge of new write data over the old lane contents.
  function automatic logic [LANE_W-1:0] byte_merge(input logic [LANE_W-1:0] old_data,
                                                   input logic [LANE_W-1:0] new_data,
                                                   input logic [3:0]        sel);
    logic [LANE_W-1:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = sel[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/marmot_sram_lane_mux.sv
// Combinational bank/lane select over the four macro read-data buses.
module marmot_sram_lane_mux
  import marmot_wb_sram_pkg::*;
(
  input  logic [RAM_DW-1:0] rdata0,
  input  logic [RAM_DW-1:0] rdata1,
  input  logic [RAM_DW-1:0] rdata2,
  input  logic [RAM_DW-1:0] rdata3,
  input  logic [BANK_W-1:0] bank,
  input  logic              lane,
  output logic [LANE_W-1:0] data
);

  logic [RAM_DW-1:0] row;

  // Pick the bank row, then the 32-bit half addressed by lane.
  always_comb begin
    row = rdata0;
    case (bank)
      2'd1:    row = rdata1;
      2'd2:    row = rdata2;
      2'd3:    row = rdata3;
      default: row = rdata0;
    endcase
    data = lane ? row[63:32] : row[31:0];
  end

endmodule

// File: rtl/marmot_wb_sram_bridge.sv
// Wishbone classic slave giving direct access to the D-cache data SRAM macros.
// Optional feature: MARMOT_WB_SRAM_RMW_EN builds read-modify-write for partial
// byte-select writes; without it partial writes land as full-lane writes.
module marmot_wb_sram_bridge
  import marmot_wb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_C000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              ram_clk,
  output logic [BANKS-1:0]  ram_csb,
  output logic              ram_web,
  output logic [ROW_W-1:0]  ram_addr,
  output logic [1:0]        ram_wmask,
  output logic [RAM_DW-1:0] ram_wdata,
  input  logic [RAM_DW-1:0] ram_rdata0,
  input  logic [RAM_DW-1:0] ram_rdata1,
  input  logic [RAM_DW-1:0] ram_rdata2,
  input  logic [RAM_DW-1:0] ram_rdata3
);

  state_t              state, state_nxt;
  logic [BANK_W-1:0]   bank_q, bank_nxt;
  logic                lane_q, lane_nxt;
  logic                we_q, we_nxt;
  logic                abort_q, abort_nxt;
  logic                ack_nxt;
  logic [31:0]         dat_nxt;
  logic [BANKS-1:0]    csb_nxt;
  logic                web_nxt;
  logic [ROW_W-1:0]    addr_nxt;
  logic [1:0]          wmask_nxt;
  logic [RAM_DW-1:0]   wdata_nxt;
  logic [LANE_W-1:0]   rd_lane;
  logic                hit, drop, partial_req, full_wr_q;
  logic                unused_adr;

`ifdef MARMOT_WB_SRAM_RMW_EN
  logic [3:0]          sel_q, sel_nxt;
  logic [31:0]         wd_q, wd_nxt;
  logic                rmw_q, rmw_nxt;
  logic [LANE_W-1:0]   merged;
  assign partial_req = (wbs_sel_i != 4'hF);
  assign full_wr_q   = we_q & ~rmw_q;
  assign merged      = byte_merge(rd_lane, wd_q, sel_q);
`else
  assign partial_req = 1'b0;
  assign full_wr_q   = we_q;
`endif

  assign ram_clk    = wb_clk_i;
  assign hit        = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  // Once cyc is seen low mid-transfer the access still finishes but no ack is given.
  assign drop       = abort_q | ~wbs_cyc_i;
  assign unused_adr = ^wbs_adr_i[1:0];

  marmot_sram_lane_mux u_mux (
    .rdata0 (ram_rdata0),
    .rdata1 (ram_rdata1),
    .rdata2 (ram_rdata2),
    .rdata3 (ram_rdata3),
    .bank   (bank_q),
    .lane   (lane_q),
    .data   (rd_lane)
  );

  // Next-state and next-value of every registered output.
  always_comb begin
    state_nxt = state;
    bank_nxt  = bank_q;
    lane_nxt  = lane_q;
    we_nxt    = we_q;
    abort_nxt = abort_q;
    ack_nxt   = 1'b0;
    dat_nxt   = wbs_dat_o;
    csb_nxt   = '1;
    web_nxt   = 1'b1;
    addr_nxt  = ram_addr;
    wmask_nxt = ram_wmask;
    wdata_nxt = ram_wdata;
`ifdef MARMOT_WB_SRAM_RMW_EN
    sel_nxt   = sel_q;
    wd_nxt    = wd_q;
    rmw_nxt   = rmw_q;
`endif
    case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
          bank_nxt = wbs_adr_i[13:12];
          lane_nxt = wbs_adr_i[2];
          we_nxt   = wbs_we_i;
`ifdef MARMOT_WB_SRAM_RMW_EN
          sel_nxt  = wbs_sel_i;
          wd_nxt   = wbs_dat_i;
          rmw_nxt  = wbs_we_i & partial_req;
`endif
          if (!hit) begin
            state_nxt = ACK;
            ack_nxt   = 1'b1;
            dat_nxt   = '0;
          end else if (wbs_we_i && wbs_sel_i == 4'h0) begin
            state_nxt = ACK;
            ack_nxt   = 1'b1;
          end else begin
            state_nxt = ISSUE;
            csb_nxt   = ~(4'b0001 << wbs_adr_i[13:12]);
            addr_nxt  = wbs_adr_i[11:3];
            // Partial writes under RMW start with a read of the row.
            if (wbs_we_i && !partial_req) begin
              web_nxt   = 1'b0;
              wmask_nxt = wbs_adr_i[2] ? 2'b10 : 2'b01;
              wdata_nxt = {wbs_dat_i, wbs_dat_i};
            end
          end
        end
      end
      ISSUE: begin
        if (!wbs_cyc_i) abort_nxt = 1'b1;
        if (full_wr_q) begin
          state_nxt = drop ? IDLE : ACK;
          ack_nxt   = ~drop;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!we_q) begin
          dat_nxt   = rd_lane;
          state_nxt = drop ? IDLE : ACK;
          ack_nxt   = ~drop;
        end else begin
`ifdef MARMOT_WB_SRAM_RMW_EN
          if (!wbs_cyc_i) abort_nxt = 1'b1;
          state_nxt = WBACK;
          csb_nxt   = ~(4'b0001 << bank_q);
          web_nxt   = 1'b0;
          wmask_nxt = lane_q ? 2'b10 : 2'b01;
          wdata_nxt = {merged, merged};
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef MARMOT_WB_SRAM_RMW_EN
      WBACK: begin
        state_nxt = drop ? IDLE : ACK;
        ack_nxt   = ~drop;
      end
`endif
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered bus/macro outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      bank_q    <= '0;
      lane_q    <= 1'b0;
      we_q      <= 1'b0;
      abort_q   <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ram_csb   <= '1;
      ram_web   <= 1'b1;
      ram_addr  <= '0;
      ram_wmask <= '0;
      ram_wdata <= '0;
`ifdef MARMOT_WB_SRAM_RMW_EN
      sel_q     <= '0;
      wd_q      <= '0;
      rmw_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      bank_q    <= bank_nxt;
      lane_q    <= lane_nxt;
      we_q      <= we_nxt;
      abort_q   <= abort_nxt;
      wbs_ack_o <= ack_nxt;
      wbs_dat_o <= dat_nxt;
      ram_csb   <= csb_nxt;
      ram_web   <= web_nxt;
      ram_addr  <= addr_nxt;
      ram_wmask <= wmask_nxt;
      ram_wdata <= wdata_nxt;
`ifdef MARMOT_WB_SRAM_RMW_EN
      sel_q     <= sel_nxt;
      wd_q      <= wd_nxt;
      rmw_q     <= rmw_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_marmot_wb_sram_bridge.sv
// Scoreboard bench for marmot_wb_sram_bridge with a behavioural SRAM macro
// model and a word-level reference memory.
module tb_marmot_wb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dout;
  logic        ram_clk;
  logic [3:0]  csb;
  logic        web;
  logic [8:0]  raddr;
  logic [1:0]  wmask;
  logic [63:0] wdata;
  logic [63:0] rdata [4];

  always #5 clk = ~clk;

  marmot_wb_sram_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dout),
    .ram_clk(ram_clk), .ram_csb(csb), .ram_web(web), .ram_addr(raddr),
    .ram_wmask(wmask), .ram_wdata(wdata),
    .ram_rdata0(rdata[0]), .ram_rdata1(rdata[1]),
    .ram_rdata2(rdata[2]), .ram_rdata3(rdata[3])
  );

  // SRAM macro model: four banks, 512 x 64, two 32-bit write lanes.
  logic [63:0] sram [4][512];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!csb[b]) begin
        if (!web) begin
          if (wmask[0]) sram[b][raddr][31:0]  <= wdata[31:0];
          if (wmask[1]) sram[b][raddr][63:32] <= wdata[63:32];
        end else begin
          rdata[b] <= sram[b][raddr];
        end
      end
    end
  end

  // Reference model: flat array of 32-bit words indexed by adr[13:2].
  logic [31:0] ref_mem [4096];

  int errors = 0, checks = 0;
  int cyc_cnt = 0;
  int acc_cnt = 0;
  logic [3:0]  last_csb;
  logic [8:0]  last_addr;
  logic [1:0]  last_wmask;
  logic        last_web;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc_cnt);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: macro activity and acknowledged responses.
  always @(negedge clk) begin
    if (csb !== 4'hF) begin
      acc_cnt++;
      last_csb   = csb;
      last_addr  = raddr;
      last_wmask = wmask;
      last_web   = web;
      chk("csb_onehot", 64'($countones(~csb)), 64'd1);
    end
    if (ack) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_cycle", 64'(cyc_cnt), 64'(e.due));
        if (e.rd) chk("rdata", {32'h0, dout}, {32'h0, e.data});
      end
    end
  end

  // One Wishbone transfer; expectations come from the reference model.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int lat, nacc, acc0, widx;
    logic hit, seen;
    logic [31:0] e;
    hit  = (a & 32'hFFFF_C000) == 32'h3000_0000;
    widx = int'(a[13:2]);
    e    = 32'h0;
    if (!hit) begin
      lat = 1; nacc = 0;
    end else if (!w) begin
      lat = 3; nacc = 1; e = ref_mem[widx];
    end else if (s == 4'h0) begin
      lat = 1; nacc = 0;
    end else if (s == 4'hF) begin
      lat = 2; nacc = 1; ref_mem[widx] = d;
    end else begin
`ifdef MARMOT_WB_SRAM_RMW_EN
      lat = 4; nacc = 2;
      for (int i = 0; i < 4; i++)
        if (s[i]) ref_mem[widx][8*i +: 8] = d[8*i +: 8];
`else
      lat = 2; nacc = 1; ref_mem[widx] = d;
`endif
    end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    acc0 = acc_cnt;
    q.push_back('{rd: !w, data: e, due: cyc_cnt + lat});
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    if (!seen) begin
      chk("ack_timeout", 64'd0, 64'd1);
      if (q.size() != 0) void'(q.pop_back());
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("macro_accesses", 64'(acc_cnt - acc0), 64'(nacc));
  endtask

  task automatic no_ack_for(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int acc0;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 512; r++) sram[b][r] = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    for (int b = 0; b < 4; b++) rdata[b] = '0;

    // Reset for 3 cycles, then check every registered output.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack",   64'(ack),   64'd0);
    chk("rst_dat",   64'(dout),  64'd0);
    chk("rst_csb",   64'(csb),   64'hF);
    chk("rst_web",   64'(web),   64'd1);
    chk("rst_addr",  64'(raddr), 64'd0);
    chk("rst_wmask", 64'(wmask), 64'd0);
    chk("rst_wdata", wdata,      64'd0);

    // Full write then read back; check macro addressing of the write.
    xfer(1'b1, 32'h3000_100C, 4'hF, 32'hDEADBEEF);
    chk("wr_csb",   64'(last_csb),   64'b1101);
    chk("wr_row",   64'(last_addr),  64'd1);
    chk("wr_wmask", 64'(last_wmask), 64'b10);
    chk("wr_web",   64'(last_web),   64'd0);
    xfer(1'b0, 32'h3000_100C, 4'hF, 32'h0);

    // Partial write over a preloaded word.
    xfer(1'b1, 32'h3000_0000, 4'hF, 32'h11223344);
    xfer(1'b1, 32'h3000_0000, 4'b0101, 32'hAABBCCDD);
    xfer(1'b0, 32'h3000_0000, 4'hF, 32'h0);

    // Miss read, zero-select write.
    xfer(1'b0, 32'h3000_4000, 4'hF, 32'h0);
    xfer(1'b1, 32'h3000_2008, 4'h0, 32'h12345678);
    xfer(1'b0, 32'h3000_2008, 4'hF, 32'h0);

    // Drop cyc during ISSUE of a read: the access completes but no ack.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_3010;
    acc0 = acc_cnt;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    no_ack_for("drop_no_ack", 6);
    chk("drop_access", 64'(acc_cnt - acc0), 64'd1);
    xfer(1'b1, 32'h3000_3010, 4'hF, 32'hCAFEF00D);
    xfer(1'b0, 32'h3000_3010, 4'hF, 32'h0);

    // Reset asserted during WAIT of a read.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_100C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait_csb", 64'(csb), 64'hF);
    chk("rstwait_ack", 64'(ack), 64'd0);
    no_ack_for("rstwait_no_ack", 5);

    // Randomized traffic over a small hit region plus occasional misses.
    for (int t = 0; t < 80; t++) begin
      logic w;
      logic [3:0] s;
      logic [31:0] a;
      int k;
      w = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 3);
      s = (k == 0) ? 4'hF : (k == 1) ? 4'h0 : 4'($urandom);
      a = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 3)
          | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_4000;
      xfer(w, a, s, $urandom);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
